// File: rtl/pattern_tx_if.sv
// pattern_tx_if: word handshake between a payload source and pattern_tx
// Signals: in_data (payload word), in_valid (word offered), in_ready (word taken on this edge)
// Modports: master drives in_data/in_valid, slave drives in_ready
interface pattern_tx_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    modport master (output in_data, in_valid, input in_ready);
    modport slave (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/pattern_tx.sv
// pattern_tx: serialises accepted words into preamble(1,0,1)/payload MSB-first/[parity]/stop(0) frames
// Ports: clk, areset_n (async active-low reset), bus (pattern_tx_if.slave: in_data, in_valid, in_ready),
//        out (registered serial bit), busy (frame in progress), frame_done (one-cycle pulse during STOP)
// Macro PATTERN_TX_PARITY_EN: when defined, an even-parity bit is sent between payload and STOP
module pattern_tx #(parameter int DATA_W = 8) (
    input  logic        clk,
    input  logic        areset_n,
    pattern_tx_if.slave bus,
    output logic        out,
    output logic        busy,
    output logic        frame_done
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [2:0] {
        IDLE, PRE0, PRE1, PRE2, DATA,
`ifdef PATTERN_TX_PARITY_EN
        PAR,
`endif
        STOP
    } state_t;
    state_t            state;
    logic [DATA_W-1:0] sr;
    logic [CW-1:0]     cnt;
    logic              accept;
`ifdef PATTERN_TX_PARITY_EN
    logic              par;
`endif
    assign bus.in_ready = (state == IDLE) || (state == STOP);
    assign accept = bus.in_valid && bus.in_ready;
    // out/busy/frame_done are loaded with the value for the state being entered,
    // so each output bit appears in the same cycle as its state.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            out        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE, STOP: begin
                    if (accept) begin
                        state <= PRE0;
                        sr    <= bus.in_data;
                        out   <= 1'b1;
                        busy  <= 1'b1;
`ifdef PATTERN_TX_PARITY_EN
                        par   <= ^bus.in_data;
`endif
                    end else begin
                        state <= IDLE;
                        out   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                PRE0: begin
                    state <= PRE1;
                    out   <= 1'b0;
                end
                PRE1: begin
                    state <= PRE2;
                    out   <= 1'b1;
                end
                PRE2: begin
                    state <= DATA;
                    cnt   <= '0;
                    out   <= sr[DATA_W-1];
                    sr    <= sr << 1;
                end
                DATA: begin
                    if (cnt == CW'(DATA_W - 1)) begin
`ifdef PATTERN_TX_PARITY_EN
                        state      <= PAR;
                        out        <= par;
`else
                        state      <= STOP;
                        out        <= 1'b0;
                        frame_done <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                        out <= sr[DATA_W-1];
                        sr  <= sr << 1;
                    end
                end
`ifdef PATTERN_TX_PARITY_EN
                PAR: begin
                    state      <= STOP;
                    out        <= 1'b0;
                    frame_done <= 1'b1;
                end
`endif
                default: begin
                    state <= IDLE;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
